// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO sizing defaults and pointer-width helper
package fifo_pkg;

  localparam int unsigned MEM_SIZE  = 4;
  localparam int unsigned WORD_SIZE = 6;
  localparam int unsigned PTR_L     = 3;

  // Pointer/count width must represent 0..MEM_SIZE inclusive.
  function automatic int unsigned min_ptr_l(input int unsigned mem_size);
    return $clog2(mem_size + 1);
  endfunction

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/ptr_counter.sv
// rtl/ptr_counter.sv - enabled modulo-MEM_SIZE address counter with synchronous clear
module ptr_counter
  import fifo_pkg::*;
#(
  parameter int unsigned MEM_SIZE = fifo_pkg::MEM_SIZE,
  parameter int unsigned PTR_L    = fifo_pkg::PTR_L
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [PTR_L-1:0] ptr_o
);

  logic [PTR_L-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PTR_L'(MEM_SIZE - 1)) ? '0 : ptr_q + PTR_L'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO pointer/occupancy controller driving a one-cycle-latency memory
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned MEM_SIZE  = fifo_pkg::MEM_SIZE,
  parameter int unsigned WORD_SIZE = fifo_pkg::WORD_SIZE,
  parameter int unsigned PTR_L     = fifo_pkg::PTR_L
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_req,
  input  logic             pop_req,
  input  logic [PTR_L-1:0] umbral_alto,
  input  logic [PTR_L-1:0] umbral_bajo,
  output logic [PTR_L-1:0] wr_ptr,
  output logic [PTR_L-1:0] rd_ptr,
  output logic             push,
  output logic             pop,
  output logic [PTR_L-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             valid_out,
  output logic             error
);

  logic [PTR_L-1:0] count_q, count_d;
  logic             valid_q;
  logic             error_q, error_d;
  fifo_op_e         op;

  assign full         = (count_q == PTR_L'(MEM_SIZE));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= umbral_alto);
  assign almost_empty = (count_q <= umbral_bajo);

  // A pop frees a slot in the same edge, so a full FIFO still accepts push+pop.
  assign pop  = !reset && pop_req && !empty;
  assign push = !reset && push_req && (!full || pop);
  assign op   = fifo_op_e'({push, pop});

  always_comb begin
    count_d = count_q;
    case (op)
      OP_PUSH: count_d = count_q + PTR_L'(1);
      OP_POP:  count_d = count_q - PTR_L'(1);
      default: count_d = count_q;
    endcase
  end

  assign error_d = error_q
                 | (push_req && full && !pop_req)
                 | (pop_req && empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= pop;
      error_q <= error_d;
    end
  end

  ptr_counter #(.MEM_SIZE(MEM_SIZE), .PTR_L(PTR_L)) u_wr_ptr (
    .clk   (clk),
    .clr_i (reset),
    .en_i  (push),
    .ptr_o (wr_ptr)
  );

  ptr_counter #(.MEM_SIZE(MEM_SIZE), .PTR_L(PTR_L)) u_rd_ptr (
    .clk   (clk),
    .clr_i (reset),
    .en_i  (pop),
    .ptr_o (rd_ptr)
  );

  assign count     = count_q;
  assign valid_out = valid_q;
  assign error     = error_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed self-checking bench for fifo_ctrl
module tb_fifo_ctrl;
  import fifo_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             push_req, pop_req;
  logic [PTR_L-1:0] umbral_alto, umbral_bajo;
  logic [PTR_L-1:0] wr_ptr, rd_ptr, count;
  logic             push, pop, full, empty, almost_full, almost_empty, valid_out, error;

  int passes = 0;
  int total  = 0;
  int valid_pulses;

  fifo_ctrl #(.MEM_SIZE(MEM_SIZE), .WORD_SIZE(WORD_SIZE), .PTR_L(PTR_L)) dut (
    .clk          (clk),
    .reset        (reset),
    .push_req     (push_req),
    .pop_req      (pop_req),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .push         (push),
    .pop          (pop),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .valid_out    (valid_out),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; push_req = 1'b1; pop_req = 1'b1;
    umbral_alto = 3'd3; umbral_bajo = 3'd1;
    #1;
    settle();
    check("push_in_reset", push, 0);
    check("pop_in_reset", pop, 0);
    tick();
    check("rst_count", count, 0);
    check("rst_wr", wr_ptr, 0);
    check("rst_rd", rd_ptr, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", valid_out, 0);
    check("rst_error", error, 0);

    // Fill: first request after reset is serviced immediately.
    reset = 1'b0; pop_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_req = 1'b1;
      settle();
      check("fill_push", push, 1);
      check("fill_wr", wr_ptr, i);
      check("fill_count", count, i);
      check("fill_ae", almost_empty, (i <= 1));
      check("fill_af", almost_full, (i >= 3));
      tick();
    end
    check("full_count", count, 4);
    check("full_wr_wrap", wr_ptr, 0);
    check("full_flag", full, 1);
    check("full_af", almost_full, 1);
    check("full_ae", almost_empty, 0);
    check("fill_error", error, 0);

    // Overflow.
    push_req = 1'b1; pop_req = 1'b0;
    settle();
    check("ovf_push", push, 0);
    tick();
    check("ovf_wr", wr_ptr, 0);
    check("ovf_count", count, 4);
    check("ovf_error", error, 1);

    // Drain and wrap; the fifth pop underflows.
    push_req = 1'b0;
    valid_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      pop_req = 1'b1;
      settle();
      check("drain_rd", rd_ptr, i % 4);
      check("drain_pop", pop, (i < 4));
      tick();
      check("drain_valid", valid_out, (i < 4));
      if (valid_out) valid_pulses++;
      check("drain_count", count, (i < 4) ? 3 - i : 0);
    end
    check("drain_pulses", valid_pulses, 4);
    check("drain_empty", empty, 1);
    check("drain_error_held", error, 1);

    // Empty plus both requests: push only.
    push_req = 1'b1; pop_req = 1'b1;
    settle();
    check("emp_both_push", push, 1);
    check("emp_both_pop", pop, 0);
    tick();
    check("emp_both_count", count, 1);
    check("emp_both_wr", wr_ptr, 1);
    check("emp_both_valid", valid_out, 0);

    pop_req = 1'b0;
    tick(); tick(); tick();
    check("refill_count", count, 4);
    check("refill_wr", wr_ptr, 0);

    // Full plus both requests: both accepted.
    push_req = 1'b1; pop_req = 1'b1;
    settle();
    check("full_both_push", push, 1);
    check("full_both_pop", pop, 1);
    tick();
    check("full_both_count", count, 4);
    check("full_both_wr", wr_ptr, 1);
    check("full_both_rd", rd_ptr, 1);
    check("full_both_valid", valid_out, 1);

    push_req = 1'b0; pop_req = 1'b1;
    tick(); tick();
    check("pre_rst_count", count, 2);
    check("pre_rst_rd", rd_ptr, 3);

    // Mid-operation reset with an in-flight valid_out.
    reset = 1'b1; push_req = 1'b1; pop_req = 1'b0;
    settle();
    check("mid_rst_push", push, 0);
    tick();
    check("mid_rst_count", count, 0);
    check("mid_rst_wr", wr_ptr, 0);
    check("mid_rst_rd", rd_ptr, 0);
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_error", error, 0);
    reset = 1'b0;
    settle();
    check("post_rst_push", push, 1);
    check("post_rst_addr", wr_ptr, 0);
    tick();
    check("post_rst_wr", wr_ptr, 1);
    check("post_rst_count", count, 1);

    // Thresholds beyond MEM_SIZE.
    push_req = 1'b0;
    umbral_alto = 3'd7; umbral_bajo = 3'd5;
    settle();
    check("big_thr_af", almost_full, 0);
    check("big_thr_ae", almost_empty, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
